// File: rtl/reg_file.sv
// Architectural register file with rename-tag table: the decoder reads operands as a value
// or a ROB tag and renames rd on issue, and the ROB commits results in order.
module reg_file #(
    parameter int REG_NUM       = 32,
    parameter int REG_POS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int ROB_POS_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     rollback,

    input  logic [REG_POS_WIDTH-1:0] rs1_idx,
    output logic                     rs1_busy,
    output logic [DATA_WIDTH-1:0]    rs1_val,
    output logic [ROB_POS_WIDTH-1:0] rs1_rob_pos,

    input  logic [REG_POS_WIDTH-1:0] rs2_idx,
    output logic                     rs2_busy,
    output logic [DATA_WIDTH-1:0]    rs2_val,
    output logic [ROB_POS_WIDTH-1:0] rs2_rob_pos,

    input  logic                     issue_en,
    input  logic [REG_POS_WIDTH-1:0] issue_rd,
    input  logic [ROB_POS_WIDTH-1:0] issue_rob_pos,

    input  logic                     commit_en,
    input  logic [REG_POS_WIDTH-1:0] commit_rd,
    input  logic [DATA_WIDTH-1:0]    commit_val,
    input  logic [ROB_POS_WIDTH-1:0] commit_rob_pos
);

    logic [DATA_WIDTH-1:0]    val_q [REG_NUM];
    logic [ROB_POS_WIDTH-1:0] tag_q [REG_NUM];
    logic [REG_NUM-1:0]       busy_q;

    // Reads see pre-issue state; a commit that retires the current producer is
    // forwarded so the decoder never waits a cycle for a value already on the bus.
    always_comb begin
        rs1_busy    = 1'b0;
        rs1_val     = '0;
        rs1_rob_pos = '0;
        if (rs1_idx != '0) begin
            rs1_rob_pos = tag_q[rs1_idx];
            if (commit_en && commit_rd == rs1_idx && busy_q[rs1_idx] &&
                tag_q[rs1_idx] == commit_rob_pos) begin
                rs1_val = commit_val;
            end else begin
                rs1_busy = busy_q[rs1_idx];
                rs1_val  = val_q[rs1_idx];
            end
        end
    end

    always_comb begin
        rs2_busy    = 1'b0;
        rs2_val     = '0;
        rs2_rob_pos = '0;
        if (rs2_idx != '0) begin
            rs2_rob_pos = tag_q[rs2_idx];
            if (commit_en && commit_rd == rs2_idx && busy_q[rs2_idx] &&
                tag_q[rs2_idx] == commit_rob_pos) begin
                rs2_val = commit_val;
            end else begin
                rs2_busy = busy_q[rs2_idx];
                rs2_val  = val_q[rs2_idx];
            end
        end
    end

    // issue_en and commit_en are single-cycle strobes with no back-pressure; they take
    // effect only on an edge where rdy is high, otherwise they are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
            busy_q <= '0;
        end else if (rdy) begin
            if (commit_en && commit_rd != '0) begin
                val_q[commit_rd] <= commit_val;
                // A stale commit (register renamed again since) must not clear busy.
                if (tag_q[commit_rd] == commit_rob_pos) begin
                    busy_q[commit_rd] <= 1'b0;
                end
            end
            if (rollback) begin
                busy_q <= '0;
            end else if (issue_en && issue_rd != '0) begin
                busy_q[issue_rd] <= 1'b1;
                tag_q[issue_rd]  <= issue_rob_pos;
            end
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: rename, commit bypass, stale commit, rollback,
// rdy hold and synchronous reset, with hand-computed expected values.
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        rollback;
    logic [4:0]  rs1_idx;
    logic        rs1_busy;
    logic [31:0] rs1_val;
    logic [3:0]  rs1_rob_pos;
    logic [4:0]  rs2_idx;
    logic        rs2_busy;
    logic [31:0] rs2_val;
    logic [3:0]  rs2_rob_pos;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic [3:0]  issue_rob_pos;
    logic        commit_en;
    logic [4:0]  commit_rd;
    logic [31:0] commit_val;
    logic [3:0]  commit_rob_pos;

    int tests_run;
    int tests_failed;
    logic [31:0] exp_q[$];

    reg_file dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .rollback       (rollback),
        .rs1_idx        (rs1_idx),
        .rs1_busy       (rs1_busy),
        .rs1_val        (rs1_val),
        .rs1_rob_pos    (rs1_rob_pos),
        .rs2_idx        (rs2_idx),
        .rs2_busy       (rs2_busy),
        .rs2_val        (rs2_val),
        .rs2_rob_pos    (rs2_rob_pos),
        .issue_en       (issue_en),
        .issue_rd       (issue_rd),
        .issue_rob_pos  (issue_rob_pos),
        .commit_en      (commit_en),
        .commit_rd      (commit_rd),
        .commit_val     (commit_val),
        .commit_rob_pos (commit_rob_pos)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // driver tasks
    task automatic clear_in();
        rdy       = 1'b1;
        rollback  = 1'b0;
        issue_en  = 1'b0;
        commit_en = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_in();
    endtask

    task automatic drive_issue(input logic [4:0] rd, input logic [3:0] pos);
        issue_en      = 1'b1;
        issue_rd      = rd;
        issue_rob_pos = pos;
    endtask

    task automatic drive_commit(input logic [4:0] rd, input logic [3:0] pos, input logic [31:0] v);
        commit_en      = 1'b1;
        commit_rd      = rd;
        commit_rob_pos = pos;
        commit_val     = v;
    endtask

    // Reads one register on both ports; rob_pos is only checked when busy is expected.
    task automatic read_chk(input string name, input logic [4:0] idx, input logic eb,
                            input logic [31:0] ev, input logic [3:0] ep);
        rs1_idx = idx;
        rs2_idx = idx;
        #1;
        check({name, ".busy1"}, {31'b0, rs1_busy}, {31'b0, eb});
        check({name, ".val1"}, rs1_val, ev);
        check({name, ".busy2"}, {31'b0, rs2_busy}, {31'b0, eb});
        check({name, ".val2"}, rs2_val, ev);
        if (eb) begin
            check({name, ".pos1"}, {28'b0, rs1_rob_pos}, {28'b0, ep});
            check({name, ".pos2"}, {28'b0, rs2_rob_pos}, {28'b0, ep});
        end
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        rst            = 1'b1;
        clear_in();
        rs1_idx        = '0;
        rs2_idx        = '0;
        issue_rd       = '0;
        issue_rob_pos  = '0;
        commit_rd      = '0;
        commit_rob_pos = '0;
        commit_val     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: reset state of every register, x0 ignores issue
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(32'h0);
        end
        for (int i = 0; i < 32; i++) begin
            rs1_idx = 5'(i);
            rs2_idx = 5'(31 - i);
            #1;
            check($sformatf("rst.busy1[%0d]", i), {31'b0, rs1_busy}, 32'h0);
            check($sformatf("rst.busy2[%0d]", 31 - i), {31'b0, rs2_busy}, 32'h0);
            check($sformatf("rst.pos1[%0d]", i), {28'b0, rs1_rob_pos}, 32'h0);
            check($sformatf("rst.val1[%0d]", i), rs1_val, exp_q.pop_front());
            check($sformatf("rst.val2[%0d]", 31 - i), rs2_val, 32'h0);
        end
        drive_issue(5'd0, 4'd3);
        tick();
        read_chk("x0_issue", 5'd0, 1'b0, 32'h0, 4'd0);
        check("x0_pos", {28'b0, rs1_rob_pos}, 32'h0);

        // 2: rename then commit with same-cycle bypass
        drive_issue(5'd5, 4'd2);
        tick();
        read_chk("x5_renamed", 5'd5, 1'b1, 32'h0, 4'd2);
        drive_commit(5'd5, 4'd2, 32'hDEAD);
        read_chk("x5_bypass", 5'd5, 1'b0, 32'hDEAD, 4'd0);
        tick();
        read_chk("x5_stored", 5'd5, 1'b0, 32'hDEAD, 4'd0);

        // 3: stale commit writes value, keeps newer rename
        drive_issue(5'd7, 4'd1);
        tick();
        drive_issue(5'd7, 4'd4);
        tick();
        drive_commit(5'd7, 4'd1, 32'd9);
        read_chk("x7_stale_nobypass", 5'd7, 1'b1, 32'h0, 4'd4);
        tick();
        read_chk("x7_stale_stored", 5'd7, 1'b1, 32'd9, 4'd4);

        // 4: commit and issue on same rd; issue not visible to same-cycle read
        drive_commit(5'd3, 4'd6, 32'h11);
        drive_issue(5'd3, 4'd8);
        read_chk("x3_issue_hidden", 5'd3, 1'b0, 32'h0, 4'd0);
        tick();
        read_chk("x3_issue_wins", 5'd3, 1'b1, 32'h11, 4'd8);
        drive_commit(5'd3, 4'd8, 32'h22);
        drive_issue(5'd3, 4'd9);
        read_chk("x3_bypass_vs_issue", 5'd3, 1'b0, 32'h22, 4'd0);
        tick();
        read_chk("x3_reissued", 5'd3, 1'b1, 32'h22, 4'd9);

        // 5: rollback with commit; issue in that cycle ignored
        drive_issue(5'd1, 4'd0);
        tick();
        drive_issue(5'd2, 4'd1);
        tick();
        drive_issue(5'd3, 4'd2);
        tick();
        read_chk("x1_pre_rb", 5'd1, 1'b1, 32'h0, 4'd0);
        read_chk("x3_pre_rb", 5'd3, 1'b1, 32'h22, 4'd2);
        rollback = 1'b1;
        drive_commit(5'd9, 4'd5, 32'h44);
        drive_issue(5'd4, 4'd7);
        tick();
        read_chk("x1_rb", 5'd1, 1'b0, 32'h0, 4'd0);
        read_chk("x2_rb", 5'd2, 1'b0, 32'h0, 4'd0);
        read_chk("x3_rb", 5'd3, 1'b0, 32'h22, 4'd0);
        read_chk("x4_rb_issue_dropped", 5'd4, 1'b0, 32'h0, 4'd0);
        read_chk("x7_rb", 5'd7, 1'b0, 32'd9, 4'd0);
        read_chk("x9_rb_commit", 5'd9, 1'b0, 32'h44, 4'd0);
        read_chk("x5_rb", 5'd5, 1'b0, 32'hDEAD, 4'd0);

        // 6: rdy low holds state, then synchronous reset clears it
        drive_issue(5'd10, 4'd3);
        tick();
        rdy = 1'b0;
        drive_issue(5'd11, 4'd5);
        drive_commit(5'd10, 4'd3, 32'h77);
        tick();
        read_chk("x10_hold", 5'd10, 1'b1, 32'h0, 4'd3);
        read_chk("x11_hold", 5'd11, 1'b0, 32'h0, 4'd0);
        rst = 1'b1;
        drive_issue(5'd12, 4'd6);
        tick();
        rst = 1'b0;
        read_chk("x5_after_rst", 5'd5, 1'b0, 32'h0, 4'd0);
        read_chk("x9_after_rst", 5'd9, 1'b0, 32'h0, 4'd0);
        read_chk("x12_after_rst", 5'd12, 1'b0, 32'h0, 4'd0);
        read_chk("x10_after_rst", 5'd10, 1'b0, 32'h0, 4'd0);
        check("x10_pos_after_rst", {28'b0, rs1_rob_pos}, 32'h0);

        // final report
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
